alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single processor ALU between two requesters: port 0 is the pipeline execute stage and port 1 is the auxiliary unit, for example address or CSR computation. It accepts one operation at a time through valid/ready handshakes and picks the winner by round-robin. It drives the ALU operand and opcode inputs from registers, captures the ALU result, and returns it on the winning requester's response channel. The ALU itself is instantiated beside this block; this block connects only to its `ALUop`, `in1`, `in2` and `out` pins.

---
 rtl/alu_share_arb.sv | 161 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arb
//  Description : Round-robin arbiter/sequencer sharing one ALU between the
//                execute stage (port 0) and an auxiliary unit (port 1).
//                One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,

    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    input  logic [W-1:0] alu_out,

    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Highest opcode the ALU implements; anything above is reported as error.
    localparam logic [3:0] C_OP_MAX = 4'd9;

    logic [1:0]   r_state_q,    w_state_d;
    logic         r_prio_q,     w_prio_d;
    logic         r_owner_q,    w_owner_d;
    logic [3:0]   r_alu_op_q,   w_alu_op_d;
    logic [W-1:0] r_alu_in1_q,  w_alu_in1_d;
    logic [W-1:0] r_alu_in2_q,  w_alu_in2_d;
    logic [W-1:0] r_rsp_data_q, w_rsp_data_d;
    logic         r_rsp_err_q,  w_rsp_err_d;

    logic         w_idle;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_rsp_ack;

    // Grant decode: a lone requester always wins, otherwise prio decides.
    // Reset is folded in so no handshake is reported while rst is high.
    always_comb begin
        w_idle    = (r_state_q == ST_IDLE) && !rst;
        w_grant0  = w_idle && req0_valid && (!r_prio_q || !req1_valid);
        w_grant1  = w_idle && req1_valid && ( r_prio_q || !req0_valid);
        w_rsp_ack = r_owner_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and datapath capture for the three-state sequencer.
    always_comb begin
        w_state_d    = r_state_q;
        w_prio_d     = r_prio_q;
        w_owner_d    = r_owner_q;
        w_alu_op_d   = r_alu_op_q;
        w_alu_in1_d  = r_alu_in1_q;
        w_alu_in2_d  = r_alu_in2_q;
        w_rsp_data_d = r_rsp_data_q;
        w_rsp_err_d  = r_rsp_err_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_grant0) begin
                    w_alu_op_d  = req0_op;
                    w_alu_in1_d = req0_a;
                    w_alu_in2_d = req0_b;
                    w_owner_d   = 1'b0;
                    w_state_d   = ST_EXEC;
                end else if (w_grant1) begin
                    w_alu_op_d  = req1_op;
                    w_alu_in1_d = req1_a;
                    w_alu_in2_d = req1_b;
                    w_owner_d   = 1'b1;
                    w_state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Illegal opcodes return zero data with the error flag so the
                // requester never sees whatever the ALU drives for them.
                if (r_alu_op_q > C_OP_MAX) begin
                    w_rsp_data_d = '0;
                    w_rsp_err_d  = 1'b1;
                end else begin
                    w_rsp_data_d = alu_out;
                    w_rsp_err_d  = 1'b0;
                end
                w_state_d = ST_RESP;
            end

            ST_RESP: begin
                if (w_rsp_ack) begin
                    w_prio_d  = ~r_owner_q;
                    w_state_d = ST_IDLE;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_prio_q     <= 1'b0;
            r_owner_q    <= 1'b0;
            r_alu_op_q   <= 4'd0;
            r_alu_in1_q  <= '0;
            r_alu_in2_q  <= '0;
            r_rsp_data_q <= '0;
            r_rsp_err_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_prio_q     <= w_prio_d;
            r_owner_q    <= w_owner_d;
            r_alu_op_q   <= w_alu_op_d;
            r_alu_in1_q  <= w_alu_in1_d;
            r_alu_in2_q  <= w_alu_in2_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_rsp_err_q  <= w_rsp_err_d;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = (r_state_q == ST_RESP) && !r_owner_q;
    assign rsp1_valid = (r_state_q == ST_RESP) &&  r_owner_q;
    assign rsp_data   = r_rsp_data_q;
    assign rsp_err    = r_rsp_err_q;
    assign alu_op     = r_alu_op_q;
    assign alu_in1    = r_alu_in1_q;
    assign alu_in2    = r_alu_in2_q;
    assign busy       = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arb
//  Description : Directed scoreboard bench for alu_share_arb with a
//                behavioural ALU attached to the alu_* pins.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        busy;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_share_arb #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; undefined opcodes drive a marker value the DUT must mask.
    always_comb begin
        case (alu_op)
            4'd0:    alu_out = alu_in1 + alu_in2;
            4'd1:    alu_out = alu_in1 - alu_in2;
            4'd2:    alu_out = alu_in1 & alu_in2;
            4'd3:    alu_out = alu_in1 | alu_in2;
            4'd4:    alu_out = alu_in1 ^ alu_in2;
            4'd5:    alu_out = ~(alu_in1 | alu_in2);
            4'd6:    alu_out = alu_in1 << alu_in2[4:0];
            4'd7:    alu_out = alu_in1 >> alu_in2[4:0];
            4'd8:    alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            4'd9:    alu_out = {31'd0, ($signed(alu_in1) < $signed(alu_in2))};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Pop the oldest expected response and compare it with the RESP outputs.
    task automatic expect_rsp(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb: observed=response expected=empty scoreboard", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_v0"}, {31'd0, rsp0_valid}, (e.port == 0) ? 32'd1 : 32'd0);
            chk({tag, "_v1"}, {31'd0, rsp1_valid}, (e.port == 1) ? 32'd1 : 32'd0);
            chk({tag, "_data"}, rsp_data, e.data);
            chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdy"},  {30'd0, req1_ready, req0_ready}, 32'd0);
        chk({tag, "_rvld"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk({tag, "_op"},   {28'd0, alu_op}, 32'd0);
        chk({tag, "_in1"},  alu_in1, 32'd0);
        chk({tag, "_in2"},  alu_in2, 32'd0);
        chk({tag, "_data"}, rsp_data, 32'd0);
        chk({tag, "_err"},  {31'd0, rsp_err}, 32'd0);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        step(); step(); settle();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single ADD on port 0
        step();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        rsp0_ready = 1'b1;
        settle();
        chk("add_rdy0", {31'd0, req0_ready}, 32'd1);
        push(0, 32'd12, 1'b0);
        step(); req0_valid = 1'b0; settle();
        chk("add_busy_exec", {31'd0, busy}, 32'd1);
        chk("add_alu_op", {28'd0, alu_op}, 32'd0);
        chk("add_alu_in1", alu_in1, 32'd5);
        chk("add_alu_in2", alu_in2, 32'd7);
        step(); settle();
        expect_rsp("add_rsp");
        step(); settle();
        chk("add_idle", {31'd0, busy}, 32'd0);

        // Simultaneous requests after reset: port 0 first
        do_reset();
        step();
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd3;      req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'hF0F0;  req1_b = 32'h0FF0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        settle();
        chk("sim_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
        push(0, 32'hFFFF_FFFE, 1'b0);
        step(); req0_valid = 1'b0; settle();
        chk("sim_exec_rdy1", {31'd0, req1_ready}, 32'd0);
        step(); settle();
        expect_rsp("sim_rsp0");
        step(); settle();
        chk("sim_rdy1_c3", {30'd0, req1_ready, req0_ready}, 32'd2);
        push(1, 32'h0000_00F0, 1'b0);
        step(); req1_valid = 1'b0;
        step(); settle();
        expect_rsp("sim_rsp1");

        // Fairness: both ports hold valid for six operations
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1;    req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'hFF;   req1_b = 32'h0F;
        for (int i = 0; i < 6; i++) begin
            step(); settle();
            chk($sformatf("fair_grant%0d", i), {30'd0, req1_ready, req0_ready},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i % 2 == 0) push(0, 32'd3, 1'b0);
            else            push(1, 32'hF0, 1'b0);
            step();
            step(); settle();
            expect_rsp($sformatf("fair_rsp%0d", i));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure on port 1 with port 0 waiting
        step();
        req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'h8000_0000; req1_b = 32'd4;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        settle();
        chk("bp_rdy1", {30'd0, req1_ready, req0_ready}, 32'd2);
        push(1, 32'hF800_0000, 1'b0);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        settle();
        chk("bp_exec_rdy0", {31'd0, req0_ready}, 32'd0);
        step(); settle();
        expect_rsp("bp_rsp");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step(); settle();
            end
            chk($sformatf("bp_vld%0d", i), {31'd0, rsp1_valid}, 32'd1);
            chk($sformatf("bp_data%0d", i), rsp_data, 32'hF800_0000);
            chk($sformatf("bp_rdy0_%0d", i), {31'd0, req0_ready}, 32'd0);
        end
        step(); rsp1_ready = 1'b1; settle();
        chk("bp_ack_vld", {31'd0, rsp1_valid}, 32'd1);
        chk("bp_ack_rdy0", {31'd0, req0_ready}, 32'd0);
        step(); settle();
        chk("bp_after_rdy0", {31'd0, req0_ready}, 32'd1);
        push(0, 32'd12, 1'b0);
        step(); req0_valid = 1'b0;
        step(); settle();
        expect_rsp("bp_rsp0");

        // Illegal opcode, then SLT
        step();
        req0_valid = 1'b1; req0_op = 4'd12; req0_a = 32'd9; req0_b = 32'd9;
        settle();
        chk("ill_rdy0", {31'd0, req0_ready}, 32'd1);
        push(0, 32'd0, 1'b1);
        step(); req0_valid = 1'b0;
        step(); settle();
        expect_rsp("ill_rsp");
        step();
        req0_valid = 1'b1; req0_op = 4'd9; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
        settle();
        chk("slt_rdy0", {31'd0, req0_ready}, 32'd1);
        push(0, 32'd1, 1'b0);
        step(); req0_valid = 1'b0;
        step(); settle();
        expect_rsp("slt_rsp");

        // Reset in EXEC abandons the operation and clears prio
        step();
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd100; req1_b = 32'd1;
        settle();
        chk("rmid_rdy1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        settle();
        chk("rmid_exec", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step(); rst = 1'b0; settle();
        check_reset_outputs("rmid");
        step(); settle();
        chk("rmid_norsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        step();
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'hA0; req0_b = 32'h05;
        req1_valid = 1'b1;
        settle();
        chk("rmid_prio", {30'd0, req1_ready, req0_ready}, 32'd1);
        push(0, 32'hA5, 1'b0);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        step(); settle();
        expect_rsp("rmid_rsp");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: observed=%0d left expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
